mem_fill_ctrl: RTL

Cache-line fill controller between the I-cache/D-cache interfaces and the multi-cycle main memory. It takes miss requests from both caches, with D-side priority, and issues eight pipelined word reads per 16-byte line. Each returned word is streamed back with its address and a one-cycle cache write-enable. The requesting side stays stalled until the line is complete. It drives the `MemData`/`MemAddress`/`MemCacheWriteEnable`/`MemStall` inputs of the MEM stage and the equivalent fetch-side inputs.

---
 rtl/mem_fill_ctrl_pkg.sv | 34 +++
 rtl/mem_fill_ctrl_if.sv | 20 ++
 rtl/mem_fill_ctrl_arbiter.sv | 30 +++
 rtl/mem_fill_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_fill_ctrl_pkg.sv
// mem_fill_ctrl_pkg
//   Shared types and constants for the cache-line fill controller.
//   - fill_state_e : 2-bit fill FSM encoding (also exported for debug)
//   - owner_e      : which cache owns the current fill (D or I)
//   - LINE_WORDS   : 16-bit words per 16-byte line
//   - LINE_MASK    : clears the word/byte offset to get the line base
//   - line_word_addr() : byte address of word <idx> inside a line
package mem_fill_ctrl_pkg;

   localparam int          LINE_WORDS  = 8;
   localparam logic [15:0] LINE_MASK   = 16'hFFF0;
   // Nominal main-memory read latency the controller is paired with.
   localparam int          MEM_LATENCY = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fill_state_e;

   typedef enum logic {
      OWNER_D = 1'b0,
      OWNER_I = 1'b1
   } owner_e;

   // The word index only replaces bits [3:1]; nothing carries into bit 4,
   // so a line near the top of memory never wraps into another line.
   function automatic logic [15:0] line_word_addr(input logic [15:0] base,
                                                  input logic [2:0]  idx);
      return base | {12'b0, idx, 1'b0};
   endfunction

endpackage

// File: rtl/mem_fill_ctrl_if.sv
// mem_fill_ctrl_if
//   Read bus between the fill controller (master) and main memory (slave).
//   - MemEnable    : master -> slave, one read issued per cycle it is high
//   - MemAddr      : master -> slave, byte address of that read
//   - MemRdData    : slave -> master, read data
//   - MemDataValid : slave -> master, MemRdData valid this cycle
// Handshake: strobe-only, no backpressure. Every cycle MemEnable is high
// is one accepted read; the memory answers each read exactly once with a
// single-cycle MemDataValid, in issue order, a fixed latency later.
interface mem_fill_ctrl_if;
   logic        MemEnable;
   logic [15:0] MemAddr;
   logic [15:0] MemRdData;
   logic        MemDataValid;

   modport master (output MemEnable, output MemAddr,
                   input  MemRdData, input  MemDataValid);
   modport slave  (input  MemEnable, input  MemAddr,
                   output MemRdData, output MemDataValid);
endinterface

// File: rtl/mem_fill_ctrl_arbiter.sv
// fill_req_arbiter
//   Combinational choice between the two cache miss requests.
//   - d_req/d_addr : D-cache miss request and byte address
//   - i_req/i_addr : I-cache miss request and byte address
//   - grant        : some request is present
//   - owner        : winning side (D has fixed priority)
//   - base         : line base address of the winner
module fill_req_arbiter
   import mem_fill_ctrl_pkg::*;
(
   input  logic        d_req,
   input  logic [15:0] d_addr,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        grant,
   output owner_e      owner,
   output logic [15:0] base
);

   always_comb begin
      grant = d_req | i_req;
      owner = OWNER_D;
      base  = d_addr & LINE_MASK;
      if (!d_req && i_req) begin
         owner = OWNER_I;
         base  = i_addr & LINE_MASK;
      end
   end

endmodule

// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl
//   Cache-line fill controller. Grants one miss (D before I), issues the
//   eight word reads of the line, streams each returned word back to the
//   owning cache with a one-cycle write-enable, and holds the requester's
//   stall until the line is complete.
//   - clk, rst           : clock, synchronous active-high reset
//   - mem_bus            : main-memory read bus (master side)
//   - DMemoryRequest/Address, IMemoryRequest/Address : miss requests
//   - FillData/FillAddress : registered word and its byte address
//   - DCacheWriteEnable/ICacheWriteEnable : registered write strobes
//   - DStall/IStall      : combinational pipeline stalls
//   - dbg_state          : current FSM state
module mem_fill_ctrl
   import mem_fill_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   mem_fill_ctrl_if.master       mem_bus,
   input  logic                  DMemoryRequest,
   input  logic [15:0]           DMemoryAddress,
   input  logic                  IMemoryRequest,
   input  logic [15:0]           IMemoryAddress,
   output logic [15:0]           FillData,
   output logic [15:0]           FillAddress,
   output logic                  DCacheWriteEnable,
   output logic                  ICacheWriteEnable,
   output logic                  DStall,
   output logic                  IStall,
   output fill_state_e           dbg_state
);

   fill_state_e state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [15:0] base_q, base_d;
   logic [2:0]  issue_cnt_q, issue_cnt_d;
   logic [3:0]  ret_cnt_q, ret_cnt_d;
   logic [15:0] fill_data_q, fill_data_d;
   logic [15:0] fill_addr_q, fill_addr_d;
   logic        d_we_q, d_we_d;
   logic        i_we_q, i_we_d;

   logic        grant;
   owner_e      grant_owner;
   logic [15:0] grant_base;

   fill_req_arbiter u_arb (
      .d_req  (DMemoryRequest),
      .d_addr (DMemoryAddress),
      .i_req  (IMemoryRequest),
      .i_addr (IMemoryAddress),
      .grant  (grant),
      .owner  (grant_owner),
      .base   (grant_base)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      base_d      = base_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      fill_data_d = fill_data_q;
      fill_addr_d = fill_addr_q;
      d_we_d      = 1'b0;
      i_we_d      = 1'b0;
      mem_bus.MemEnable = 1'b0;
      mem_bus.MemAddr   = 16'h0000;

      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d     = ST_ISSUE;
               owner_d     = grant_owner;
               base_d      = grant_base;
               issue_cnt_d = 3'd0;
               ret_cnt_d   = 4'd0;
            end
         end
         ST_ISSUE: begin
            mem_bus.MemEnable = 1'b1;
            mem_bus.MemAddr   = line_word_addr(base_q, issue_cnt_q);
            issue_cnt_d       = issue_cnt_q + 3'd1;
            if (issue_cnt_q == 3'(LINE_WORDS - 1)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // ret_cnt reaches LINE_WORDS the cycle the last word's
            // write-enable is on the outputs; DONE follows it.
            if (ret_cnt_q == 4'(LINE_WORDS)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Returns overlap issuing, so they are accepted in ISSUE and DRAIN.
      if ((state_q == ST_ISSUE || state_q == ST_DRAIN) &&
          mem_bus.MemDataValid && (ret_cnt_q < 4'(LINE_WORDS))) begin
         fill_data_d = mem_bus.MemRdData;
         fill_addr_d = line_word_addr(base_q, ret_cnt_q[2:0]);
         ret_cnt_d   = ret_cnt_q + 4'd1;
         if (owner_q == OWNER_D) begin
            d_we_d = 1'b1;
         end else begin
            i_we_d = 1'b1;
         end
      end

      // Read strobe and address are forced quiet while reset is held.
      if (rst) begin
         mem_bus.MemEnable = 1'b0;
         mem_bus.MemAddr   = 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWNER_D;
         base_q      <= 16'h0000;
         issue_cnt_q <= 3'd0;
         ret_cnt_q   <= 4'd0;
         fill_data_q <= 16'h0000;
         fill_addr_q <= 16'h0000;
         d_we_q      <= 1'b0;
         i_we_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         base_q      <= base_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         fill_data_q <= fill_data_d;
         fill_addr_q <= fill_addr_d;
         d_we_q      <= d_we_d;
         i_we_q      <= i_we_d;
      end
   end

   // A side is released only in the DONE cycle of its own fill; a side
   // queued behind the other's fill stays stalled throughout.
   assign DStall = DMemoryRequest & ~((state_q == ST_DONE) && (owner_q == OWNER_D));
   assign IStall = IMemoryRequest & ~((state_q == ST_DONE) && (owner_q == OWNER_I));

   assign FillData          = fill_data_q;
   assign FillAddress       = fill_addr_q;
   assign DCacheWriteEnable = d_we_q;
   assign ICacheWriteEnable = i_we_q;
   assign dbg_state         = state_q;

endmodule
